// File: rtl/pipe_rate_ctrl.sv
// Purpose: PIPE rate / PCLK-change controller between the LTSSM and a multi-lane PIPE PHY.
// Latency: accept -> done in >= 4 pclk edges (accept, eidle, PclkChangeOk, last PhyStatus); bad or same-gen requests answer on the accept edge.
// Backpressure: req_ready is high only in IDLE; req_valid while busy is dropped, never queued.
//
// Ports: pclk/reset_n (async active-low); req_valid/req_gen/active_lanes request in,
// req_ready/busy status; elec_idle_ok, PclkChangeOk, PhyStatus from LTSSM/PHY;
// Rate/PCLKRate/width/PclkChangeAck to the PHY; GEN settled generation; done/error pulses.
module pipe_rate_ctrl #(
    parameter int LANESNUMBER    = 16,
    parameter int MAX_GEN        = 3,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   pclk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    input  logic [2:0]             req_gen,
    output logic                   req_ready,
    input  logic [LANESNUMBER-1:0] active_lanes,
    input  logic                   elec_idle_ok,
    input  logic                   PclkChangeOk,
    input  logic [LANESNUMBER-1:0] PhyStatus,
    output logic [3:0]             Rate,
    output logic [4:0]             PCLKRate,
    output logic [1:0]             width,
    output logic                   PclkChangeAck,
    output logic [2:0]             GEN,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     MAX_G   = 3'(MAX_GEN);

    typedef enum logic [1:0] {IDLE, WAIT_EIDLE, WAIT_OK, WAIT_PHY} state_t;

    function automatic int pw_of(input logic [2:0] g);
        case (g)
            3'd2:    return GEN2_PIPEWIDTH;
            3'd3:    return GEN3_PIPEWIDTH;
            3'd4:    return GEN4_PIPEWIDTH;
            3'd5:    return GEN5_PIPEWIDTH;
            default: return GEN1_PIPEWIDTH;
        endcase
    endfunction

    function automatic logic [1:0] wcode_of(input logic [2:0] g);
        int w;
        w = pw_of(g);
        return (w == 32) ? 2'd2 : ((w == 16) ? 2'd1 : 2'd0);
    endfunction

    // PCLK = 62.5 MHz * 2^k, k = (gen+1) - wcode: a wider PIPE bus needs a slower PCLK.
    function automatic logic [4:0] pclk_of(input logic [2:0] g);
        return 5'(g) + 5'd1 - 5'(wcode_of(g));
    endfunction

    function automatic logic [3:0] rate_of(input logic [2:0] g);
        return 4'(g) - 4'd1;
    endfunction

    state_t                   state, state_nxt;
    logic [2:0]               tgt, gen_q;
    logic [LANESNUMBER-1:0]   mask, sticky;
    logic [CW-1:0]            cnt;
    logic                     acc_err, acc_same, load_tgt, go_phy, complete, timeout;

    always_comb begin
        state_nxt = state;
        acc_err   = 1'b0;
        acc_same  = 1'b0;
        load_tgt  = 1'b0;
        go_phy    = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_gen == 3'd0 || req_gen > MAX_G || active_lanes == '0) begin
                        acc_err = 1'b1;
                    end else if (req_gen == gen_q) begin
                        acc_same = 1'b1;
                    end else begin
                        state_nxt = WAIT_EIDLE;
                    end
                end
            end
            WAIT_EIDLE: begin
                if (elec_idle_ok) begin
                    load_tgt  = 1'b1;
                    state_nxt = WAIT_OK;
                end
            end
            WAIT_OK: begin
                // The PHY saw the new rate late: giving up takes priority over acking.
                if (cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else if (PclkChangeOk) begin
                    go_phy    = 1'b1;
                    state_nxt = WAIT_PHY;
                end
            end
            WAIT_PHY: begin
                // Include this cycle's pulses so the last lane completes on its own edge;
                // completion beats a coincident timeout.
                if ((sticky | (PhyStatus & mask)) == mask) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            tgt           <= 3'd1;
            gen_q         <= 3'd1;
            mask          <= '0;
            sticky        <= '0;
            cnt           <= '0;
            Rate          <= rate_of(3'd1);
            PCLKRate      <= pclk_of(3'd1);
            width         <= wcode_of(3'd1);
            PclkChangeAck <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= acc_same | complete;
            error <= acc_err | timeout;

            if (state == IDLE && req_valid) begin
                tgt  <= req_gen;
                mask <= active_lanes;
            end

            // Counter runs across WAIT_OK and WAIT_PHY as one budget.
            if (state == WAIT_OK || state == WAIT_PHY) begin
                cnt <= cnt + CW'(1);
            end
            if (state == WAIT_PHY) begin
                sticky <= sticky | (PhyStatus & mask);
            end

            if (load_tgt) begin
                Rate     <= rate_of(tgt);
                PCLKRate <= pclk_of(tgt);
                width    <= wcode_of(tgt);
                cnt      <= '0;
            end
            if (go_phy) begin
                PclkChangeAck <= 1'b1;
                sticky        <= '0;
            end
            if (complete) begin
                PclkChangeAck <= 1'b0;
                gen_q         <= tgt;
            end
            if (timeout) begin
                PclkChangeAck <= 1'b0;
                Rate          <= rate_of(gen_q);
                PCLKRate      <= pclk_of(gen_q);
                width         <= wcode_of(gen_q);
            end
        end
    end

    assign GEN       = gen_q;
    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

endmodule

// File: tb/tb_pipe_rate_ctrl.sv
// Purpose: randomized + directed scoreboard bench for pipe_rate_ctrl.
// Latency: stimulus is cycle-scheduled relative to the accept edge.
// Backpressure: spurious requests are injected while busy and must be dropped.
module tb_pipe_rate_ctrl;

    localparam int NL  = 16;
    localparam int MAXG = 3;
    localparam int G2W = 32;
    localparam int G3W = 16;
    localparam int TO  = 16;

    logic            pclk = 1'b0;
    logic            reset_n;
    logic            req_valid;
    logic [2:0]      req_gen;
    logic            req_ready;
    logic [NL-1:0]   active_lanes;
    logic            elec_idle_ok;
    logic            PclkChangeOk;
    logic [NL-1:0]   PhyStatus;
    logic [3:0]      Rate;
    logic [4:0]      PCLKRate;
    logic [1:0]      width;
    logic            PclkChangeAck;
    logic [2:0]      GEN;
    logic            busy;
    logic            done;
    logic            error;

    pipe_rate_ctrl #(
        .LANESNUMBER(NL), .MAX_GEN(MAXG),
        .GEN1_PIPEWIDTH(8), .GEN2_PIPEWIDTH(G2W), .GEN3_PIPEWIDTH(G3W),
        .GEN4_PIPEWIDTH(8), .GEN5_PIPEWIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .reset_n(reset_n), .req_valid(req_valid), .req_gen(req_gen),
        .req_ready(req_ready), .active_lanes(active_lanes), .elec_idle_ok(elec_idle_ok),
        .PclkChangeOk(PclkChangeOk), .PhyStatus(PhyStatus), .Rate(Rate),
        .PCLKRate(PCLKRate), .width(width), .PclkChangeAck(PclkChangeAck), .GEN(GEN),
        .busy(busy), .done(done), .error(error)
    );

    always #5 pclk = ~pclk;

    // Reference model: codes derived directly from the generation and its PIPE width.
    function automatic int pw_m(input int g);
        case (g)
            2:       return G2W;
            3:       return G3W;
            default: return 8;
        endcase
    endfunction
    function automatic int wc_m(input int g);
        return (pw_m(g) == 32) ? 2 : ((pw_m(g) == 16) ? 1 : 0);
    endfunction
    function automatic int pk_m(input int g);
        return g + 1 - wc_m(g);
    endfunction

    typedef struct {
        bit is_err;
        int gen;   // GEN (and code set) expected right after the pulse
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cur_gen = 1;
    int   pt[NL];   // per-lane PhyStatus pulse edge (relative to WAIT_OK entry), 0 = none

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check_codes(input string tag, input int g);
        check({tag, "_rate"},  int'(Rate),     g - 1);
        check({tag, "_pclk"},  int'(PCLKRate), pk_m(g));
        check({tag, "_width"}, int'(width),    wc_m(g));
    endtask

    // Monitor: pops one expectation per done/error pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (done && error) check("done_error_overlap", 1, 0);
            if (done || error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'(done), int'(error) + 2);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_err", int'(error), int'(e.is_err));
                    check("pulse_gen", int'(GEN), e.gen);
                    check_codes("pulse", e.gen);
                end
            end
        end
    end

    // One request: a = edge (after accept) sampling elec_idle_ok high,
    // b = edge (after WAIT_OK entry) where PclkChangeOk first goes high (>= TO means never in time).
    task automatic run_req(input int g, input logic [NL-1:0] m, input int a, input int b);
        exp_t e;
        int   c, fin, ack_e;
        bit   ok_path, comp;
        req_valid    = 1'b1;
        req_gen      = 3'(g);
        active_lanes = m;
        elec_idle_ok = 1'b0;
        if (g < 1 || g > MAXG || m == '0 || g == cur_gen) begin
            e.is_err = !(g >= 1 && g <= MAXG && m != '0);
            e.gen    = cur_gen;
            exp_q.push_back(e);
            step();
            req_valid = 1'b0;
            check("imm_busy", int'(busy), 0);
            check("imm_gen", int'(GEN), cur_gen);
            check_codes("imm", cur_gen);
            step();
            return;
        end
        step();
        req_valid = 1'b0;
        check("accept_busy", int'(busy), 1);
        check("accept_ready", int'(req_ready), 0);
        for (int j = 1; j <= a; j++) begin
            elec_idle_ok = (j == a);
            step();
        end
        check_codes("loaded", g);
        check("loaded_ack", int'(PclkChangeAck), 0);
        check("loaded_gen", int'(GEN), cur_gen);

        ok_path = (b < TO);
        comp    = ok_path;
        c       = 0;
        for (int i = 0; i < NL; i++) begin
            if (m[i]) begin
                if (pt[i] > b) c = (pt[i] > c) ? pt[i] : c;
                else           comp = 1'b0;
            end
        end
        if (c > TO) comp = 1'b0;
        fin      = comp ? c : TO;
        e.is_err = !comp;
        e.gen    = comp ? g : cur_gen;
        exp_q.push_back(e);

        for (int k = 1; k <= fin + 2; k++) begin
            PclkChangeOk = (k >= b);
            for (int i = 0; i < NL; i++) PhyStatus[i] = (pt[i] == k);
            req_valid    = (k == 1);
            req_gen      = 3'($urandom_range(0, 7));
            active_lanes = NL'($urandom);
            step();
            req_valid = 1'b0;
            ack_e = (ok_path && k >= b && k < fin) ? 1 : 0;
            check("hs_ack", int'(PclkChangeAck), ack_e);
            check("hs_busy", int'(busy), (k < fin) ? 1 : 0);
            check("hs_rate", int'(Rate), ((k < fin || comp) ? g : cur_gen) - 1);
        end
        PclkChangeOk = 1'b0;
        PhyStatus    = '0;
        elec_idle_ok = 1'b0;
        if (comp) cur_gen = g;
        step();
    endtask

    task automatic clear_pt();
        for (int i = 0; i < NL; i++) pt[i] = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gen"}, int'(GEN), 1);
        check_codes(tag, 1);
        check({tag, "_ack"}, int'(PclkChangeAck), 0);
        check({tag, "_ready"}, int'(req_ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pulses"}, int'(done) + int'(error), 0);
    endtask

    initial begin
        int g, a, b, r, sel;
        logic [NL-1:0] m;
        reset_n = 1'b0; req_valid = 1'b0; req_gen = '0; active_lanes = '0;
        elec_idle_ok = 1'b0; PclkChangeOk = 1'b0; PhyStatus = '0;
        clear_pt();
        repeat (3) step();
        check_reset_vals("reset");
        @(negedge pclk); reset_n = 1'b1;
        step();

        // Gen1 -> Gen3, all lanes, PhyStatus staggered two lanes per cycle.
        for (int i = 0; i < NL; i++) pt[i] = 6 + i / 2;
        run_req(3, 16'hFFFF, 1, 5);
        // Illegal gen, same gen, empty mask.
        run_req(4, 16'hFFFF, 1, 1);
        run_req(3, 16'h0001, 1, 1);
        run_req(2, 16'h0000, 1, 1);
        // Timeout with PclkChangeOk never asserted.
        clear_pt();
        run_req(2, 16'h00FF, 2, 99);
        // Partial mask, spurious lane-8 pulse during WAIT_OK.
        clear_pt();
        pt[8] = 2; pt[0] = 4; pt[1] = 5; pt[2] = 6; pt[3] = 7;
        run_req(1, 16'h000F, 3, 3);
        // Completion on the timeout edge wins; one cycle later loses.
        clear_pt(); pt[0] = TO;
        run_req(2, 16'h0001, 1, 10);
        clear_pt(); pt[0] = TO + 1;
        run_req(3, 16'h0001, 1, 10);

        // Reset in WAIT_PHY with Ack high.
        reset_n = 1'b0; step(); reset_n = 1'b1; cur_gen = 1; step();
        req_valid = 1'b1; req_gen = 3'd2; active_lanes = 16'h0001; elec_idle_ok = 1'b1;
        step(); req_valid = 1'b0;
        step(); PclkChangeOk = 1'b1;
        step();
        check("pre_reset_ack", int'(PclkChangeAck), 1);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("midreset");
        PclkChangeOk = 1'b0; elec_idle_ok = 1'b0;
        @(negedge pclk); reset_n = 1'b1;
        step();
        clear_pt(); pt[0] = 2;
        run_req(2, 16'h0001, 1, 1);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            g   = $urandom_range(0, 5);
            sel = $urandom_range(0, 19);
            if (sel == 0)      m = '0;
            else if (sel < 4)  m = 16'hFFFF;
            else if (sel < 8)  m = NL'(1) << $urandom_range(0, NL - 1);
            else               m = NL'($urandom & $urandom);
            a = $urandom_range(1, 4);
            b = ($urandom_range(0, 6) == 0) ? 99 : $urandom_range(1, 11);
            for (int i = 0; i < NL; i++) begin
                r = $urandom_range(0, 14);
                if (r == 0)      pt[i] = 0;
                else if (r == 1) pt[i] = $urandom_range(1, (b < TO) ? b : TO);
                else             pt[i] = ((b < TO) ? b : 0) + $urandom_range(1, 6);
            end
            run_req(g, m, a, b);
        end

        repeat (4) step();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
